// File: rtl/mcpu_soc_mmio_pkg.sv
// Shared types and helpers for the SoC MMIO slot protocol.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mcpu_soc_mmio_pkg;

   // Initiator transaction phases: wait for request, strobe slot, hold response.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } mmio_state_t;

   // Expand 4 byte enables into the 32-bit per-bit write mask used by the slots.
   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/mcpu_soc_mmio_initiator.sv
// CPU-side request to MMIO slot initiator: decodes a word address to one of NPERIPH slots.
// Latency: accept -> resp_valid is 2 cycles; one transaction per 3 cycles at best.
// Backpressure: req_ready low from accept until the cycle after the response is consumed.
module mcpu_soc_mmio_initiator #(
   parameter int          NPERIPH = 4,
   parameter int          PADDR_W = 4,
   parameter logic [31:0] BASE    = 32'h3FFF0
) (
   input  logic                    clkrst_core_clk,
   input  logic                    clkrst_core_rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [31:0]             req_addr,
   input  logic                    req_write,
   input  logic [31:0]             req_wdata,
   input  logic [3:0]              req_wbe,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [31:0]             resp_rdata,
   output logic                    resp_err,
   output logic [NPERIPH-1:0]      mmio_sel,
   output logic [PADDR_W-1:0]      mmio_addr,
   output logic [31:0]             mmio_data_in,
   output logic [31:0]             mmio_write_mask,
   input  logic [NPERIPH*32-1:0]   mmio_data_out
);
   import mcpu_soc_mmio_pkg::*;

   localparam int SLOT_W   = $clog2(NPERIPH);
   localparam int SLOT_LSB = 2 + PADDR_W;
   localparam int BASE_LSB = SLOT_LSB + SLOT_W;

   mmio_state_t         state;
   logic [SLOT_W-1:0]   req_slot;
   logic                req_hit;
   logic [NPERIPH-1:0]  req_onehot;
   logic [SLOT_W-1:0]   acc_slot;
   logic                acc_write;
   logic                acc_hit;
   logic [31:0]         acc_rdata;

   // Decode the incoming request: slot index, BASE match and one-hot strobe.
   always_comb begin
      req_slot             = req_addr[SLOT_LSB +: SLOT_W];
      req_hit              = ((req_addr >> BASE_LSB) == BASE);
      req_onehot           = '0;
      req_onehot[req_slot] = 1'b1;
   end

   // Select the addressed slot's combinational read data during ACCESS.
   always_comb begin
      acc_rdata = mmio_data_out[{acc_slot, 5'd0} +: 32];
   end

   // Transaction FSM; every MMIO and response output is a flop so slots never see glitches.
   always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
      if (clkrst_core_rst) begin
         state           <= ST_IDLE;
         req_ready       <= 1'b1;
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_err        <= 1'b0;
         mmio_sel        <= '0;
         mmio_addr       <= '0;
         mmio_data_in    <= '0;
         mmio_write_mask <= '0;
         acc_slot        <= '0;
         acc_write       <= 1'b0;
         acc_hit         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  state     <= ST_ACCESS;
                  req_ready <= 1'b0;
                  acc_slot  <= req_slot;
                  acc_write <= req_write;
                  acc_hit   <= req_hit;
                  // A failed BASE decode strobes nothing; the slot lines stay quiet.
                  if (req_hit) begin
                     mmio_sel        <= req_onehot;
                     mmio_addr       <= req_addr[2 +: PADDR_W];
                     mmio_data_in    <= req_wdata;
                     mmio_write_mask <= req_write ? be_to_mask(req_wbe) : 32'h0;
                  end
               end
            end
            ST_ACCESS: begin
               state           <= ST_RESP;
               mmio_sel        <= '0;
               mmio_addr       <= '0;
               mmio_data_in    <= '0;
               mmio_write_mask <= '0;
               resp_valid      <= 1'b1;
               resp_err        <= ~acc_hit;
               resp_rdata      <= (acc_hit && !acc_write) ? acc_rdata : 32'h0;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state      <= ST_IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state           <= ST_IDLE;
               req_ready       <= 1'b1;
               resp_valid      <= 1'b0;
               mmio_sel        <= '0;
               mmio_write_mask <= '0;
            end
         endcase
      end
   end

endmodule
